// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the DCCM load/store controller.
//   - request size encodings
//   - controller state encoding
//   - default DCCM window
//   - pending-request record captured at accept
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] DCCM_BASE_DEF  = 32'h0001_0000;
    localparam int unsigned DCCM_BYTES_DEF = 65536;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef struct packed {
        logic       is_load;
        logic       err;
        logic [1:0] size;
        logic       uns;
        logic [1:0] offset;
    } pend_t;

endpackage

// File: rtl/lsu_dccm_ctrl_if.sv
// lsu_dccm_ctrl_if: request/response handshakes plus the DCCM port.
//   slave  : the controller (accepts requests, drives responses and DCCM strobes)
//   master : the environment (execute stage issuing requests, CCM returning read data)
interface lsu_dccm_ctrl_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    // response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // DCCM port
    logic        dccm_wr_en;
    logic        dccm_rd_en;
    logic [31:0] dccm_wr_addr;
    logic [31:0] dccm_rd_addr;
    logic [31:0] dccm_wr_data;
    logic [1:0]  store_type;
    logic [1:0]  store_offset;
    logic [31:0] dccm_rd_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
        output store_type, store_offset,
        input  dccm_rd_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
        input  store_type, store_offset,
        output dccm_rd_data
    );

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: moves the addressed lane of a DCCM read word down to bit 0,
// then masks to the access size and sign/zero-extends.
//   rdata       in  32  word read from DCCM
//   offset      in  2   byte offset of the access within the word
//   size        in  2   SZ_B / SZ_H / SZ_W
//   is_unsigned in  1   zero-extend when 1
//   data        out 32  extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] sh;
    logic        sgn_b;
    logic        sgn_h;

    assign sh    = rdata >> {offset, 3'b000};
    assign sgn_b = ~is_unsigned & sh[7];
    assign sgn_h = ~is_unsigned & sh[15];

    always_comb begin
        data = sh;
        case (size)
            SZ_B:    data = {{24{sgn_b}}, sh[7:0]};
            SZ_H:    data = {{16{sgn_h}}, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_dccm_ctrl.sv
// lsu_dccm_ctrl: core-side initiator for the DCCM port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_dccm_ctrl_if.slave
//     req_*    : load/store request (valid/ready)
//     resp_*   : load data / error response (valid/ready), one cycle after accept
//     dccm_*, store_type, store_offset : DCCM strobes and passthroughs
// One request in flight; a response can retire and a new request be accepted
// in the same cycle, so back-to-back traffic runs at one request per cycle.
module lsu_dccm_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DCCM_BASE  = DCCM_BASE_DEF,
    parameter int unsigned DCCM_BYTES = DCCM_BYTES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_dccm_ctrl_if.slave   bus
);

    state_t      state_q, state_d;
    pend_t       pend_q;
    logic        rdy_q;      // holds req_ready low while in reset
    logic        first_q;    // first RESP cycle: DCCM read data is live
    logic [31:0] hold_q;
    logic [31:0] off;
    logic        in_range;
    logic        req_err;
    logic        ready;
    logic        accept;
    logic [31:0] aligned;
    logic [31:0] load_data;

    // ---------------- request checks ----------------
    assign off      = bus.req_addr - DCCM_BASE;
    assign in_range = (bus.req_addr >= DCCM_BASE) && (off < DCCM_BYTES);

    always_comb begin
        req_err = ~in_range;
        case (bus.req_size)
            SZ_B:    ;
            SZ_H:    if (bus.req_addr[0])          req_err = 1'b1;
            SZ_W:    if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    assign ready  = rdy_q & ((state_q == IDLE) | ((state_q == RESP) & bus.resp_ready));
    assign accept = bus.req_valid & ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = accept ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- pending info and load hold ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            first_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            first_q <= accept;
            if (accept) begin
                pend_q.is_load <= ~bus.req_we;
                pend_q.err     <= req_err;
                pend_q.size    <= bus.req_size;
                pend_q.uns     <= bus.req_unsigned;
                pend_q.offset  <= bus.req_addr[1:0];
            end
            // DCCM data is only guaranteed for one cycle; keep it for stalls
            if (first_q) hold_q <= aligned;
        end
    end

    lsu_load_align u_align (
        .rdata       (bus.dccm_rd_data),
        .offset      (pend_q.offset),
        .size        (pend_q.size),
        .is_unsigned (pend_q.uns),
        .data        (aligned)
    );

    assign load_data = first_q ? aligned : hold_q;

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready  = ready;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.dccm_wr_en = accept & ~req_err & bus.req_we;
        bus.dccm_rd_en = accept & ~req_err & ~bus.req_we;
        if (state_q == RESP) begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = pend_q.err;
            if (pend_q.is_load && !pend_q.err) bus.resp_rdata = load_data;
        end
    end

    assign bus.dccm_wr_addr = bus.req_addr;
    assign bus.dccm_rd_addr = bus.req_addr;
    assign bus.dccm_wr_data = bus.req_wdata;
    assign bus.store_type   = bus.req_size;
    assign bus.store_offset = bus.req_addr[1:0];

endmodule

// File: doc/lsu_dccm_ctrl.md
Name: lsu_dccm_ctrl

Overview:
- Core-side initiator for the DCCM port of the closely-coupled memory (CCM) block; sits between the execute stage and the CCM.
- Accepts load/store requests over a valid/ready handshake and checks alignment and address range.
- Drives the DCCM read/write strobes, store_type and store_offset.
- Captures the 1-cycle-latency read data, then lane-shifts and sign/zero-extends it and returns a response over a valid/ready handshake.
- At most one request in flight; full throughput of 1 request per cycle when responses are consumed immediately.

Parameters:
- DCCM_BASE, 32'h0001_0000, byte base address of the DCCM window.
- DCCM_BYTES, 65536, DCCM size in bytes (power of two; window is DCCM_BASE .. DCCM_BASE+DCCM_BYTES-1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend when 1
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid&resp_ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal size
- dccm_wr_en  out  1  DCCM write strobe
- dccm_rd_en  out  1  DCCM read strobe
- dccm_wr_addr  out  32  equals req_addr
- dccm_rd_addr  out  32  equals req_addr
- dccm_wr_data  out  32  equals req_wdata, unshifted; the memory places lanes
- store_type  out  2  equals req_size
- store_offset  out  2  equals req_addr[1:0]
- dccm_rd_data  in  32  word at the read word address, valid the cycle after dccm_rd_en

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - req_ready rises in the first cycle after rst_n deasserts.
  - Reset asserted mid-operation drops any pending read or response; no DCCM strobe is generated afterwards.
- Error check (combinational, on the accepted request); err = any of:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr outside the DCCM window
- Accept rule:
  - req_ready = (state==IDLE) | (state==RESP & resp_ready).
  - A response can therefore be consumed and a new request accepted in the same cycle.
- DCCM strobes:
  - On accept with no error, dccm_wr_en=req_we and dccm_rd_en=!req_we, combinationally in the accept cycle.
  - The address, data, store_type and store_offset outputs are combinational passthroughs.
  - Both strobes are 0 on erroring requests and when nothing is accepted.
- States:
  - IDLE: on accept go to RESP.
  - RESP: resp_valid=1. On resp_ready: go to RESP if a new request is accepted that cycle, else IDLE. Without resp_ready: hold.
- Pending info registered at accept: is_load, err, size, unsigned, offset.
- Load data path:
  - In the first RESP cycle after a load, dccm_rd_data is shifted right by 8*offset.
  - The result is masked to size and extended (sign from bit 7/15 unless unsigned; word passes through).
  - It is presented on resp_rdata and simultaneously written into a hold register.
  - In later stalled RESP cycles, resp_rdata comes from the hold register. The DCCM output is not required to be stable after one cycle.
- Responses:
  - Stores: resp_rdata=0, resp_err=0. The write is complete at the accept edge.
  - Errors: resp_err=1, resp_rdata=0, one cycle after accept like any other response.
  - Latency: accept cycle N gives resp_valid in cycle N+1.
- Outputs stay stable while resp_valid=1 and resp_ready=0.

Decomposition:
- Shared package lsu_pkg:
  - size encoding constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - state encoding IDLE/RESP.
  - default DCCM_BASE/DCCM_BYTES.
- One sub-module, lsu_load_align: combinational shift, mask and extend of (rdata, offset, size, unsigned).
- FSM, checks and hold register remain in lsu_dccm_ctrl.

Test Plan:
- Store byte, then load signed byte:
  - Store addr 0x10003, wdata 0x000000F0, size 00 -> dccm_wr_en=1, store_type=00, store_offset=11 in the accept cycle.
  - Load addr 0x10003, size 00, signed, with dccm_rd_data=0xF0AABBCC -> resp_rdata=0xFFFFFFF0, resp_err=0, one cycle after accept.
- Load unsigned half:
  - Load addr 0x10002, size 01, unsigned, with dccm_rd_data=0x8001_1234 -> resp_rdata=0x00008001.
- Misaligned and out-of-range:
  - Word load at 0x10002 -> no strobes, resp_err=1, resp_rdata=0.
  - Store at 0x0000_0100 -> no strobes, resp_err=1.
- Backpressure:
  - Load word 0x10000, dccm_rd_data=0xDEADBEEF for one cycle then 0, resp_ready low for 3 cycles -> resp_rdata holds 0xDEADBEEF, req_ready=0 throughout.
  - Then resp_ready=1 with a new request valid -> new request accepted in that same cycle.
- Back-to-back:
  - 4 consecutive word loads with resp_ready=1 -> 4 responses in 4 consecutive cycles, in order.
- Reset mid-load:
  - rst_n low in the cycle after a load is accepted -> resp_valid=0, state IDLE, no strobes after release until a new request.
